ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX bundle and the `forward_a`/`forward_b` selects from the forwarding unit. Resolves operands, performs the ALU operation, branch compare and jump-target computation, and registers the result into the EX/MEM pipeline register. The registered `exmem_alu_result` is also the EX/MEM forwarding source fed back into its own operand muxes.

## Interface
- `XLEN`, 32, datapath width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `idex_valid`  in  1  EX holds a real instruction.
- `idex_pc`  in  XLEN  instruction PC.
- `idex_rs1_data`, `idex_rs2_data`  in  XLEN  register-file operands.
- `idex_imm`  in  XLEN  sign-extended immediate.
- `idex_alu_op`  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; 11-15 yield 0.
- `idex_alu_src_pc`  in  1  operand A = `idex_pc` (AUIPC).
- `idex_alu_src_imm`  in  1  operand B = `idex_imm`.
- `idex_branch`, `idex_jal`, `idex_jalr`  in  1 each  control-flow class.
- `idex_funct3`  in  3  branch condition / memory size.
- `idex_rd`  in  5; `idex_reg_write`, `idex_mem_read`, `idex_mem_write`  in  1 each.
- `forward_a`, `forward_b`  in  2  00 register file, 10 `exmem_alu_result`, 01 `wb_data`, 11 treated as 00.
- `wb_data`  in  XLEN  MEM/WB writeback value.
- `stall`  in  1  hold the EX/MEM register.
- `flush`  in  1  load a bubble into EX/MEM.
- `redirect_valid`  out  1  taken branch or jump.
- `redirect_pc`  out  XLEN  target PC.
- `exmem_valid`, `exmem_reg_write`, `exmem_mem_read`, `exmem_mem_write`  out  1 each.
- `exmem_rd`  out  5; `exmem_funct3`  out  3.
- `exmem_alu_result`, `exmem_store_data`  out  XLEN.

## Operation
- **Forwarded operands `fa`/`fb`:** selected per `forward_a`/`forward_b` from rs1/rs2 data.
- **ALU inputs:**
  - A = `idex_pc` if `idex_alu_src_pc`, else `fa`.
  - B = `idex_imm` if `idex_alu_src_imm`, else `fb`.
- **ALU rules:**
  - Shifts use B[4:0]; SRA is arithmetic.
  - SLT is signed and SLTU unsigned; both return 1 or 0.
  - Add and subtract wrap mod 2^XLEN.
- **Branch compare:** always on `fa` vs `fb`, never on the immediate.
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - Funct3 010 and 011 are never taken.
- **Targets:**
  - Branch and JAL: `idex_pc + idex_imm`.
  - JALR: `(fa + idex_imm) & ~1`.
- **Result:**
  - JAL/JALR: `exmem_alu_result` = `idex_pc + 4`.
  - Otherwise it is the ALU output.
  - `exmem_store_data` = `fb`; it is forwarded, never the immediate.
- **`redirect_valid`** = `idex_valid & !stall & !flush & (jal | jalr | (branch & taken))`. It is combinational and asserts only for the cycle the instruction leaves EX.
- **Load results:** `exmem_alu_result` is the load *address*. The hazard unit guarantees a one-cycle load-use stall, so this block performs no load-result check.

## Timing
- **Reset:** while `rst` is high, every `exmem_*` output is 0 asynchronously, including `exmem_valid` = 0.
  - `redirect_*` is a combinational function of its inputs and carries no state.
- **Latency:** one cycle. Inputs sampled at edge N appear on `exmem_*` after edge N.
- **Per-edge update priority:**
  1. `flush`: `exmem_valid`, `exmem_reg_write`, `exmem_mem_read` and `exmem_mem_write` go to 0. The other fields are don't-care and are held.
  2. `stall`: all `exmem_*` outputs hold their values.
  3. `!idex_valid`: same as flush (bubble).
  4. Otherwise: load the new bundle.
- **Simultaneous flush and stall:** flush wins.
- **Self-forwarding while stalled:** the `forward_a = 10` path reads the held `exmem_alu_result`. The value stays consistent because both sides hold.
- **Reset mid-stream:** in-flight EX/MEM contents are discarded. The first edge after `rst` falls loads normally.
- **rd = x0:** passed through unchanged. Suppressing the write is the responsibility of writeback and forwarding.

## Test plan
1. **Reset during traffic.** Assert `rst` mid-stream → all `exmem_*` outputs are 0 immediately and `exmem_valid` = 0; after release, the next edge loads the presented bundle.
2. **Forwarding and ALU arithmetic.**
   - ADD with `forward_a` = 10 (`exmem_alu_result` = 5) and `forward_b` = 01 (`wb_data` = 7) → `exmem_alu_result` = 12 one cycle later.
   - SUB 0 − 1 → `0xFFFFFFFF`.
   - SRA `0x80000000` by 4 → `0xF8000000`.
3. **Branch compare.**
   - BLT with `fa` = −1, `fb` = 1, pc = `0x100`, imm = `0x20` → `redirect_valid` = 1, `redirect_pc` = `0x120`.
   - BLTU with the same operands → not taken.
4. **JALR.** `fa` = `0x1003`, imm = 0, pc = `0x40` → `redirect_pc` = `0x1002`, `exmem_alu_result` = `0x44`.
5. **Stall and flush.**
   - Hold `stall` for 2 cycles → `exmem_*` is unchanged and `redirect_valid` = 0.
   - Stall and flush in the same cycle → `exmem_valid` = 0 and `exmem_reg_write` = 0 next cycle.
6. **Store data.** Store with `forward_b` = 01 and `wb_data` = `0xDEADBEEF` → `exmem_store_data` = `0xDEADBEEF`, `exmem_mem_write` = 1, `exmem_alu_result` = rs1 + imm.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch
// compare, jump-target generation and the EX/MEM pipeline register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idex_valid,
  input  logic [XLEN-1:0] idex_pc,
  input  logic [XLEN-1:0] idex_rs1_data,
  input  logic [XLEN-1:0] idex_rs2_data,
  input  logic [XLEN-1:0] idex_imm,
  input  logic [3:0]      idex_alu_op,
  input  logic            idex_alu_src_pc,
  input  logic            idex_alu_src_imm,
  input  logic            idex_branch,
  input  logic            idex_jal,
  input  logic            idex_jalr,
  input  logic [2:0]      idex_funct3,
  input  logic [4:0]      idex_rd,
  input  logic            idex_reg_write,
  input  logic            idex_mem_read,
  input  logic            idex_mem_write,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] wb_data,
  input  logic            stall,
  input  logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            exmem_valid,
  output logic            exmem_reg_write,
  output logic            exmem_mem_read,
  output logic            exmem_mem_write,
  output logic [4:0]      exmem_rd,
  output logic [2:0]      exmem_funct3,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_store_data
);

  logic [XLEN-1:0] fa, fb;
  logic [XLEN-1:0] alu_a, alu_b, alu_out;
  logic [4:0]      shamt;
  logic            taken;
  logic [XLEN-1:0] jalr_sum, branch_target, link_pc, result;

  // Operand forwarding; select 11 falls back to the register file.
  always_comb begin
    case (forward_a)
      2'b10:   fa = exmem_alu_result;
      2'b01:   fa = wb_data;
      default: fa = idex_rs1_data;
    endcase
    case (forward_b)
      2'b10:   fb = exmem_alu_result;
      2'b01:   fb = wb_data;
      default: fb = idex_rs2_data;
    endcase
  end

  assign alu_a = idex_alu_src_pc  ? idex_pc  : fa;
  assign alu_b = idex_alu_src_imm ? idex_imm : fb;
  assign shamt = alu_b[4:0];

  // ALU; undefined opcodes produce zero.
  always_comb begin
    case (idex_alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a << shamt;
      4'd3:    alu_out = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      4'd4:    alu_out = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      4'd5:    alu_out = alu_a ^ alu_b;
      4'd6:    alu_out = alu_a >> shamt;
      4'd7:    alu_out = $signed(alu_a) >>> shamt;
      4'd8:    alu_out = alu_a | alu_b;
      4'd9:    alu_out = alu_a & alu_b;
      4'd10:   alu_out = alu_b;
      default: alu_out = '0;
    endcase
  end

  // Branch condition uses forwarded register operands, never the immediate.
  always_comb begin
    case (idex_funct3)
      3'b000:  taken = (fa == fb);
      3'b001:  taken = (fa != fb);
      3'b100:  taken = ($signed(fa) < $signed(fb));
      3'b101:  taken = ($signed(fa) >= $signed(fb));
      3'b110:  taken = (fa < fb);
      3'b111:  taken = (fa >= fb);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum       = fa + idex_imm;
  assign branch_target  = idex_pc + idex_imm;
  assign link_pc        = idex_pc + XLEN'(4);
  assign redirect_pc    = idex_jalr ? (jalr_sum & ~XLEN'(1)) : branch_target;
  assign redirect_valid = idex_valid & ~stall & ~flush &
                          (idex_jal | idex_jalr | (idex_branch & taken));
  assign result         = (idex_jal | idex_jalr) ? link_pc : alu_out;

  // EX/MEM register: flush beats stall; a bubble only clears the control bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_valid      <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_rd         <= '0;
      exmem_funct3     <= '0;
      exmem_alu_result <= '0;
      exmem_store_data <= '0;
    end else if (flush || (!stall && !idex_valid)) begin
      exmem_valid      <= 1'b0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
    end else if (!stall) begin
      exmem_valid      <= 1'b1;
      exmem_reg_write  <= idex_reg_write;
      exmem_mem_read   <= idex_mem_read;
      exmem_mem_write  <= idex_mem_write;
      exmem_rd         <= idex_rd;
      exmem_funct3     <= idex_funct3;
      exmem_alu_result <= result;
      exmem_store_data <= fb;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_valid;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [3:0]  idex_alu_op;
  logic        idex_alu_src_pc, idex_alu_src_imm;
  logic        idex_branch, idex_jal, idex_jalr;
  logic [2:0]  idex_funct3;
  logic [4:0]  idex_rd;
  logic        idex_reg_write, idex_mem_read, idex_mem_write;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] wb_data;
  logic        stall, flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]  exmem_rd;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_result, exmem_store_data;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .idex_valid(idex_valid), .idex_pc(idex_pc),
    .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
    .idex_imm(idex_imm), .idex_alu_op(idex_alu_op),
    .idex_alu_src_pc(idex_alu_src_pc), .idex_alu_src_imm(idex_alu_src_imm),
    .idex_branch(idex_branch), .idex_jal(idex_jal), .idex_jalr(idex_jalr),
    .idex_funct3(idex_funct3), .idex_rd(idex_rd),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write),
    .forward_a(forward_a), .forward_b(forward_b), .wb_data(wb_data),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .exmem_rd(exmem_rd), .exmem_funct3(exmem_funct3),
    .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_val);
    end
  endtask

  // Default: valid register-register ADD writing x1, no forwarding.
  task automatic idle_bundle();
    idex_valid = 1'b1; idex_pc = 32'h0; idex_rs1_data = 32'h0; idex_rs2_data = 32'h0;
    idex_imm = 32'h0; idex_alu_op = 4'd0; idex_alu_src_pc = 1'b0; idex_alu_src_imm = 1'b0;
    idex_branch = 1'b0; idex_jal = 1'b0; idex_jalr = 1'b0; idex_funct3 = 3'b000;
    idex_rd = 5'd1; idex_reg_write = 1'b1; idex_mem_read = 1'b0; idex_mem_write = 1'b0;
    forward_a = 2'b00; forward_b = 2'b00; wb_data = 32'h0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_bundle();
    rst = 1'b1;
    #1;
    check("reset_valid", 32'(exmem_valid), 32'd0);
    check("reset_result", exmem_alu_result, 32'h0);
    check("reset_rd", 32'(exmem_rd), 32'd0);
    step(); step();
    rst = 1'b0;

    // ADD 2+3 into x5
    idle_bundle(); idex_rs1_data = 32'd2; idex_rs2_data = 32'd3; idex_rd = 5'd5;
    step();
    check("add_result", exmem_alu_result, 32'd5);
    check("add_valid", 32'(exmem_valid), 32'd1);
    check("add_rd", 32'(exmem_rd), 32'd5);

    // ADD with fa from EX/MEM (5) and fb from WB (7)
    idle_bundle(); idex_rs1_data = 32'd100; idex_rs2_data = 32'd200;
    forward_a = 2'b10; forward_b = 2'b01; wb_data = 32'd7;
    step();
    check("fwd_add", exmem_alu_result, 32'd12);

    // Forward select 11 behaves like register file
    idle_bundle(); idex_rs1_data = 32'd40; idex_rs2_data = 32'd2;
    forward_a = 2'b11; forward_b = 2'b11; wb_data = 32'd999;
    step();
    check("fwd_11", exmem_alu_result, 32'd42);

    // Reset mid-stream: asynchronous clear
    idle_bundle(); idex_rs1_data = 32'd9; idex_rs2_data = 32'd9;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(exmem_valid), 32'd0);
    check("midrst_result", exmem_alu_result, 32'h0);
    check("midrst_regwr", 32'(exmem_reg_write), 32'd0);
    // Release and load SUB 0-1 on the next edge
    rst = 1'b0;
    idle_bundle(); idex_alu_op = 4'd1; idex_rs1_data = 32'd0; idex_rs2_data = 32'd1;
    step();
    check("sub_wrap", exmem_alu_result, 32'hFFFF_FFFF);
    check("post_rst_valid", 32'(exmem_valid), 32'd1);

    // SRA 0x80000000 by imm 4
    idle_bundle(); idex_alu_op = 4'd7; idex_rs1_data = 32'h8000_0000;
    idex_imm = 32'd4; idex_alu_src_imm = 1'b1;
    step();
    check("sra", exmem_alu_result, 32'hF800_0000);

    // SRL same operands, SLL uses only B[4:0]
    idle_bundle(); idex_alu_op = 4'd6; idex_rs1_data = 32'h8000_0000; idex_rs2_data = 32'd4;
    step();
    check("srl", exmem_alu_result, 32'h0800_0000);
    idle_bundle(); idex_alu_op = 4'd2; idex_rs1_data = 32'd1; idex_rs2_data = 32'h21;
    step();
    check("sll_mask", exmem_alu_result, 32'd2);

    // SLT / SLTU with -1 vs 1
    idle_bundle(); idex_alu_op = 4'd3; idex_rs1_data = 32'hFFFF_FFFF; idex_rs2_data = 32'd1;
    step();
    check("slt", exmem_alu_result, 32'd1);
    idle_bundle(); idex_alu_op = 4'd4; idex_rs1_data = 32'hFFFF_FFFF; idex_rs2_data = 32'd1;
    step();
    check("sltu", exmem_alu_result, 32'd0);

    // AUIPC-style: A = pc, B = imm; undefined op 12 gives 0
    idle_bundle(); idex_alu_src_pc = 1'b1; idex_alu_src_imm = 1'b1;
    idex_pc = 32'h200; idex_imm = 32'h1000; idex_rs1_data = 32'h5;
    step();
    check("auipc", exmem_alu_result, 32'h1200);
    idle_bundle(); idex_alu_op = 4'd12; idex_rs1_data = 32'h5; idex_rs2_data = 32'h6;
    step();
    check("op_undef", exmem_alu_result, 32'h0);

    // BLT -1 < 1 taken
    idle_bundle(); idex_branch = 1'b1; idex_reg_write = 1'b0; idex_funct3 = 3'b100;
    idex_rs1_data = 32'hFFFF_FFFF; idex_rs2_data = 32'd1; idex_pc = 32'h100; idex_imm = 32'h20;
    #1;
    check("blt_taken", 32'(redirect_valid), 32'd1);
    check("blt_target", redirect_pc, 32'h120);
    // BLTU same operands not taken
    idex_funct3 = 3'b110;
    #1;
    check("bltu_not", 32'(redirect_valid), 32'd0);
    // Funct3 010 never taken; BEQ uses fb, not imm
    idex_funct3 = 3'b010;
    #1;
    check("b010_not", 32'(redirect_valid), 32'd0);
    idex_funct3 = 3'b000; idex_rs1_data = 32'h20; idex_rs2_data = 32'h7;
    #1;
    check("beq_uses_fb", 32'(redirect_valid), 32'd0);
    step();

    // JALR: fa 0x1003, imm 0, pc 0x40, rd = x0 passes through
    idle_bundle(); idex_jalr = 1'b1; idex_rs1_data = 32'h1003; idex_pc = 32'h40; idex_rd = 5'd0;
    #1;
    check("jalr_valid", 32'(redirect_valid), 32'd1);
    check("jalr_target", redirect_pc, 32'h1002);
    step();
    check("jalr_link", exmem_alu_result, 32'h44);
    check("jalr_rd0", 32'(exmem_rd), 32'd0);

    // Known result 30 in x7, then a stalled JAL for two cycles
    idle_bundle(); idex_rs1_data = 32'd10; idex_rs2_data = 32'd20; idex_rd = 5'd7;
    step();
    check("pre_stall", exmem_alu_result, 32'd30);
    idle_bundle(); idex_jal = 1'b1; idex_pc = 32'h300; idex_imm = 32'h40; idex_rd = 5'd9;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_redir", 32'(redirect_valid), 32'd0);
      step();
      check("stall_result", exmem_alu_result, 32'd30);
      check("stall_rd", 32'(exmem_rd), 32'd7);
      check("stall_valid", 32'(exmem_valid), 32'd1);
    end
    // Stall released: JAL leaves EX
    stall = 1'b0;
    #1;
    check("jal_valid", 32'(redirect_valid), 32'd1);
    check("jal_target", redirect_pc, 32'h340);
    step();
    check("jal_link", exmem_alu_result, 32'h304);

    // Stall and flush together: flush wins
    idle_bundle(); idex_jal = 1'b1; stall = 1'b1; flush = 1'b1;
    #1;
    check("flush_redir", 32'(redirect_valid), 32'd0);
    step();
    check("flush_valid", 32'(exmem_valid), 32'd0);
    check("flush_regwr", 32'(exmem_reg_write), 32'd0);

    // Store: rs1 0x1000 + imm 8, store data forwarded from WB
    idle_bundle(); idex_reg_write = 1'b0; idex_mem_write = 1'b1; idex_funct3 = 3'b010;
    idex_rs1_data = 32'h1000; idex_imm = 32'h8; idex_alu_src_imm = 1'b1;
    idex_rs2_data = 32'h1111_1111; forward_b = 2'b01; wb_data = 32'hDEAD_BEEF;
    step();
    check("st_data", exmem_store_data, 32'hDEAD_BEEF);
    check("st_memwr", 32'(exmem_mem_write), 32'd1);
    check("st_addr", exmem_alu_result, 32'h1008);
    check("st_funct3", 32'(exmem_funct3), 32'd2);

    // Bubble: control cleared, data held
    idle_bundle(); idex_valid = 1'b0; idex_rs1_data = 32'd77;
    step();
    check("bub_valid", 32'(exmem_valid), 32'd0);
    check("bub_memwr", 32'(exmem_mem_write), 32'd0);
    check("bub_held", exmem_alu_result, 32'h1008);

    // Load: mem_read set, result is the address
    idle_bundle(); idex_mem_read = 1'b1; idex_rs1_data = 32'h2000;
    idex_imm = 32'hFFFF_FFFC; idex_alu_src_imm = 1'b1;
    step();
    check("ld_addr", exmem_alu_result, 32'h1FFC);
    check("ld_memrd", 32'(exmem_mem_read), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
